// File: rtl/dcm_lock_sequencer.sv
// dcm_lock_sequencer: reset/lock bring-up sequencer for two cascaded DCM_SP stages
// Ports: Clk_In/Rst_N clock and async active-low reset; Restart re-runs the sequence;
//        Dcm{1,2}_Locked/Status raw DCM indications; Dcm{1,2}_Rst DCM resets;
//        Clocks_Ready both stages settled; Fault retries exhausted; Retry_Count failed attempts.
// Option: DCM_STATUS_MON_EN treats STATUS[1]/[2] (input/output clock stopped) as a lock drop.
module dcm_lock_sequencer #(
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 250000,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 18
) (
  input  logic       Clk_In,
  input  logic       Rst_N,
  input  logic       Restart,
  input  logic       Dcm1_Locked,
  input  logic [7:0] Dcm1_Status,
  input  logic       Dcm2_Locked,
  input  logic [7:0] Dcm2_Status,
  output logic       Dcm1_Rst,
  output logic       Dcm2_Rst,
  output logic       Clocks_Ready,
  output logic       Fault,
  output logic [1:0] Retry_Count
);
  typedef enum logic [2:0] {RST_ALL, WAIT1, SETTLE1, WAIT2, SETTLE2, READY, FAULT} state_t;
  localparam logic [CNT_W-1:0] RST_END = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_END = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_END  = CNT_W'(LOCK_TIMEOUT - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [17:0]      meta_q, sync_q;
  logic [1:0]       retry_q, retry_d;
  logic             dcm1_rst_q, dcm1_rst_d, dcm2_rst_q, dcm2_rst_d;
  logic             ready_q, ready_d, fault_q, fault_d;
  logic             lock1, lock2, bad1, bad2, ok1, ok2, fail;
  logic [7:0]       st1, st2;
  logic             unused_status;
  assign {st2, st1, lock2, lock1} = sync_q;
`ifdef DCM_STATUS_MON_EN
  assign bad1 = st1[1] | st1[2];
  assign bad2 = st2[1] | st2[2];
`else
  assign bad1 = 1'b0;
  assign bad2 = 1'b0;
`endif
  assign unused_status = ^{st1, st2};
  assign ok1 = lock1 & ~bad1;
  assign ok2 = lock2 & ~bad2;
  always_comb begin
    state_d = state_q;
    fail    = 1'b0;
    case (state_q)
      RST_ALL: state_d = (timer_q == RST_END) ? WAIT1 : RST_ALL;
      WAIT1:   if (lock1) state_d = SETTLE1; else fail = (timer_q == TO_END);
      SETTLE1: if (!ok1) fail = 1'b1; else if (timer_q == SET_END) state_d = WAIT2;
      WAIT2:   if (!ok1) fail = 1'b1; else if (lock2) state_d = SETTLE2; else fail = (timer_q == TO_END);
      SETTLE2: if (!(ok1 && ok2)) fail = 1'b1; else if (timer_q == SET_END) state_d = READY;
      READY:   fail = !(ok1 && ok2);
      default: state_d = FAULT;
    endcase
    retry_d = retry_q;
    if (fail) begin
      retry_d = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
      state_d = (int'(retry_q) + 1 < MAX_RETRIES) ? RST_ALL : FAULT;
    end
    if (Restart) begin
      state_d = RST_ALL;
      retry_d = 2'd0;
    end else if (state_d == READY) begin
      retry_d = 2'd0;
    end
    // Any entry, including a Restart re-entry of RST_ALL, restarts the timer.
    timer_d    = (Restart || state_d != state_q) ? '0 : (&timer_q ? timer_q : timer_q + 1'b1);
    dcm1_rst_d = state_d inside {RST_ALL, FAULT};
    dcm2_rst_d = !(state_d inside {WAIT2, SETTLE2, READY});
    // Ready lags READY entry by one cycle but drops on the same edge the state leaves.
    ready_d    = (state_q == READY) && (state_d == READY);
    fault_d    = (state_d == FAULT);
  end
  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q    <= RST_ALL;
      timer_q    <= '0;
      meta_q     <= '0;
      sync_q     <= '0;
      retry_q    <= 2'd0;
      dcm1_rst_q <= 1'b1;
      dcm2_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      meta_q     <= {Dcm2_Status, Dcm1_Status, Dcm2_Locked, Dcm1_Locked};
      sync_q     <= meta_q;
      retry_q    <= retry_d;
      dcm1_rst_q <= dcm1_rst_d;
      dcm2_rst_q <= dcm2_rst_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end
  assign Dcm1_Rst     = dcm1_rst_q;
  assign Dcm2_Rst     = dcm2_rst_q;
  assign Clocks_Ready = ready_q;
  assign Fault        = fault_q;
  assign Retry_Count  = retry_q;
endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// tb_dcm_lock_sequencer: directed self-checking bench for dcm_lock_sequencer
module tb_dcm_lock_sequencer;
  typedef struct {
    int         n;
    logic       l1;
    logic       l2;
    logic [5:0] exp;
  } vec_t;
`ifdef DCM_STATUS_MON_EN
  localparam logic [5:0] ST_EXP = 6'b110001;
`else
  localparam logic [5:0] ST_EXP = 6'b001000;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       restart = 1'b0;
  logic       l1 = 1'b0, l2 = 1'b0;
  logic [7:0] d1s = 8'h00, d2s = 8'h00;
  logic       r1, r2, rdy, flt;
  logic [1:0] cnt;
  logic [5:0] obs;
  int         n_chk = 0, n_fail = 0;
  vec_t       tv [9];
  dcm_lock_sequencer #(.SETTLE_CYCLES(16), .LOCK_TIMEOUT(100)) dut (
    .Clk_In(clk), .Rst_N(rst_n), .Restart(restart),
    .Dcm1_Locked(l1), .Dcm1_Status(d1s), .Dcm2_Locked(l2), .Dcm2_Status(d2s),
    .Dcm1_Rst(r1), .Dcm2_Rst(r2), .Clocks_Ready(rdy), .Fault(flt), .Retry_Count(cnt)
  );
  assign obs = {r1, r2, rdy, flt, cnt};
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(input string nm, input logic [5:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got {rst1,rst2,rdy,flt,cnt}=%b expected %b", nm, obs, exp);
    end
  endtask
  task automatic wait_ready(input string nm);
    for (int i = 0; i < 100 && !rdy; i++) tick();
    check(nm, 6'b001000);
  endtask
  initial begin
    tv[0] = '{3,  1'b0, 1'b0, 6'b110000};
    tv[1] = '{1,  1'b0, 1'b0, 6'b010000};
    tv[2] = '{16, 1'b0, 1'b0, 6'b010000};
    tv[3] = '{18, 1'b1, 1'b0, 6'b010000};
    tv[4] = '{1,  1'b1, 1'b0, 6'b000000};
    tv[5] = '{30, 1'b1, 1'b0, 6'b000000};
    tv[6] = '{19, 1'b1, 1'b1, 6'b000000};
    tv[7] = '{1,  1'b1, 1'b1, 6'b001000};
    tv[8] = '{10, 1'b1, 1'b1, 6'b001000};
    #2 rst_n = 1'b0;
    tick(3);
    check("reset", 6'b110000);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      l1 = tv[k].l1;
      l2 = tv[k].l2;
      tick(tv[k].n);
      check($sformatf("bringup[%0d]", k), tv[k].exp);
    end
    l2 = 1'b0;
    tick();
    l2 = 1'b1;
    tick();
    check("drop_not_yet", 6'b001000);
    tick();
    check("drop_seen", 6'b110001);
    tick(3);
    check("retry_rst_hold", 6'b110001);
    tick();
    check("retry_rst_end", 6'b010001);
    tick(34);
    check("retry_ready_entry", 6'b000000);
    tick();
    check("retry_ready", 6'b001000);
    l2 = 1'b0;
    tick();
    l2 = 1'b1;
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_wins", 6'b110000);
    wait_ready("restart_ready");
    d1s = 8'h02;
    tick(2);
    check("status_pending", 6'b001000);
    tick();
    check("status_mon", ST_EXP);
    d1s = 8'h00;
    l2 = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_clear", 6'b110000);
    tick(20);
    check("settle1_end", 6'b010000);
    tick();
    check("wait2_entry", 6'b000000);
    tick(99);
    check("wait2_timeout_edge", 6'b000000);
    tick();
    check("wait2_timeout", 6'b110001);
    tick(21);
    check("wait2_again", 6'b000001);
    #3 rst_n = 1'b0;
    #1 check("async_reset", 6'b110000);
    l1 = 1'b0;
    l2 = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(103);
    check("to1_edge", 6'b010000);
    tick();
    check("to1", 6'b110001);
    tick(3);
    check("to1_rst_hold", 6'b110001);
    tick();
    check("to1_rst_end", 6'b010001);
    tick(99);
    check("to2_edge", 6'b010001);
    tick();
    check("to2", 6'b110010);
    tick(103);
    check("to3_edge", 6'b010010);
    tick();
    check("fault", 6'b110111);
    tick(100);
    check("fault_hold", 6'b110111);
    l1 = 1'b1;
    l2 = 1'b1;
    tick(5);
    check("fault_ignores_lock", 6'b110111);
    restart = 1'b1;
    l1 = 1'b0;
    tick();
    restart = 1'b0;
    l1 = 1'b1;
    check("fault_restart", 6'b110000);
    tick(3);
    check("fault_restart_rst", 6'b110000);
    tick();
    check("fault_restart_wait1", 6'b010000);
    wait_ready("fault_restart_ready");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
